riscv_alu_div_ctrl: RTL
=======================

Name: riscv_alu_div_ctrl

Overview:
Initiator-side controller for the serial divider; it sits between the ALU/EX-stage request interface and the divider's input/output handshake. It latches core operands and computes the normalisation shift. It then left-aligns operand B, derives the sign/zero flags, issues the request, waits for completion and captures the result. The core sees a stall-free valid/ready result interface, and a kill can abandon an operation safely.

Parameters:
C_WIDTH, 32, operand/result width
C_LOG_WIDTH, 6, width of shift count; must equal $clog2(C_WIDTH+1)

Ports:
Clk_CI  in  1  clock
Rst_RI  in  1  reset, synchronous, active-high
Req_SI  in  1  core request valid
Gnt_SO  out  1  request accepted this cycle
OpA_DI  in  C_WIDTH  dividend
OpB_DI  in  C_WIDTH  divisor
OpCode_SI  in  2  0 udiv, 1 div, 2 urem, 3 rem
Kill_SI  in  1  abandon current operation
Valid_SO  out  1  result valid to core
Rdy_SI  in  1  core consumes result
Result_DO  out  C_WIDTH  captured result
DivOpA_DO  out  C_WIDTH  to divider OpA
DivOpB_DO  out  C_WIDTH  normalised divisor (B << s)
DivOpBShift_DO  out  C_LOG_WIDTH  s
DivOpBIsZero_SO  out  1  B == 0
DivOpBSign_SO  out  1  OpCode[0] & B[MSB]
DivOpCode_DO  out  2  registered opcode
DivInVld_SO  out  1  issue strobe
DivOutVld_SI  in  1  divider idle/result valid
DivOutRdy_SO  out  1  result drained

Behaviour:
- Reset (Rst_RI high at posedge): state IDLE. Valid_SO, DivInVld_SO, DivOutRdy_SO and Gnt_SO are 0. Result_DO and all Div* data outputs are 0.
- Normalisation: unsigned, s = lzc(B). Signed, s = (count of leading bits equal to B[MSB]) - 1. If B == 0, s = C_WIDTH-1 and DivOpBIsZero=1. DivOpB = B << s (logical).
- IDLE: Gnt_SO = Req_SI. On Req_SI, register A, B<<s, s, flags and opcode, then go to ISSUE. The Div* outputs are driven only from these registers.
- ISSUE: DivInVld_SO = DivOutVld_SI; the request is issued only while the divider is idle. When both are high, go to WAIT.
- WAIT: DivOutRdy_SO = DivOutVld_SI. When DivOutVld_SI is high, capture DivRes into Result_DO and go to DONE. The first WAIT cycle always sees DivOutVld_SI=0.
- DONE: Valid_SO=1, and Result_DO is held stable until Rdy_SI. On Rdy_SI with no Req_SI, go to IDLE. On Rdy_SI with Req_SI, Gnt_SO=1, the new operands are latched and the state goes to ISSUE (back-to-back).
- Latency, Req to Valid: s+4 cycles (1 latch, 1 issue, s+1 divide, 1 finish/capture).
- Kill in ISSUE or DONE: go to IDLE next cycle; no issue occurs and Valid is dropped.
- Kill in WAIT: go to DRAIN. DRAIN sets DivOutRdy_SO = DivOutVld_SI, discards the result and returns to IDLE when DivOutVld_SI is high. Gnt_SO=0 during DRAIN.
- Kill in IDLE: ignored.
- Kill and Rdy_SI together in DONE: Kill wins; no re-grant.
- Reset in any state returns to IDLE the next cycle. The divider shares reset, so no drain is needed.
- Signed overflow (MIN/-1) and divide-by-zero results are whatever the divider produces; no correction is applied.
- Result data input: DivRes_DI  in  C_WIDTH, sampled only in WAIT.

Optional Feature:
- Macro RISCV_DIV_FASTPATH_EN.
- When defined: in IDLE, if B==0 or B==1, the divider is bypassed and the state goes directly to DONE, with Valid at the next cycle (latency 1).
  - B==0: quotient = all ones; remainder = A.
  - B==1: quotient = A; remainder = 0.
  - The divider sees no DivInVld.
- When undefined: all operations go through the divider.

Decomposition:
- Package riscv_div_pkg holds:
  - Opcode enum (DIV_UDIV=0, DIV_DIV=1, DIV_UREM=2, DIV_REM=3).
  - FSM state enum (IDLE, ISSUE, WAIT, DONE, DRAIN).
- Sub-module riscv_div_norm: combinational leading-zero/leading-sign count plus left shifter, producing s, B<<s and the zero flag.

Test Plan:
- udiv 100/7: s=29, DivOpB=0xE0000000; Valid at cycle 33; Result=14. Same operands as urem: Result=2.
- div -100/7: Result=0xFFFFFFF2 (-14). As rem: Result=0xFFFFFFFE (-2). DivOpBSign=0.
- udiv 5/0: DivOpBIsZero=1, s=31, Result=0xFFFFFFFF. urem 5/0: Result=5. With RISCV_DIV_FASTPATH_EN: Valid at cycle 1 and no DivInVld.
- Back-to-back: Rdy_SI held low 3 cycles, then Rdy_SI=1 and Req_SI=1 in DONE. The first Result is held stable, Gnt_SO=1 and the second op issues the next cycle.
- Kill at WAIT cycle 5: DRAIN asserts DivOutRdy on the divider's finish and Valid_SO never rises. A next request 12/4 udiv gives Result=3.
- Reset asserted mid-WAIT: all outputs are 0 the next cycle. The divider is idle afterwards and a new request completes correctly.

Source files
------------

// File: rtl/riscv_div_pkg.sv
// Shared types for the serial-divider initiator: opcode encoding and controller FSM states.
package riscv_div_pkg;

    typedef enum logic [1:0] {
        DIV_UDIV = 2'd0,
        DIV_DIV  = 2'd1,
        DIV_UREM = 2'd2,
        DIV_REM  = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        DRAIN = 3'd4
    } div_state_e;

endpackage

// File: rtl/riscv_div_norm.sv
// Divisor normalisation: leading-zero (unsigned) or redundant-sign (signed) count,
// then a logical left shift so the divisor's significant bits are left-aligned.
module riscv_div_norm #(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6
) (
    input  logic [C_WIDTH-1:0]     b_i,
    input  logic                   signed_i,
    output logic [C_WIDTH-1:0]     b_norm_o,
    output logic [C_LOG_WIDTH-1:0] shift_o,
    output logic                   zero_o
);

    logic                   ref_bit;
    logic                   found;
    logic [C_LOG_WIDTH-1:0] lead_cnt;

    assign ref_bit = signed_i & b_i[C_WIDTH-1];
    assign zero_o  = (b_i == '0);

    // Number of leading bits equal to ref_bit; C_WIDTH when every bit matches.
    always_comb begin
        lead_cnt = C_LOG_WIDTH'(C_WIDTH);
        found    = 1'b0;
        for (int i = C_WIDTH - 1; i >= 0; i--) begin
            if (!found && (b_i[i] != ref_bit)) begin
                lead_cnt = C_LOG_WIDTH'(C_WIDTH - 1 - i);
                found    = 1'b1;
            end
        end
    end

    always_comb begin
        if (zero_o) begin
            shift_o = C_LOG_WIDTH'(C_WIDTH - 1);
        end else if (signed_i) begin
            shift_o = lead_cnt - C_LOG_WIDTH'(1);
        end else begin
            shift_o = lead_cnt;
        end
    end

    assign b_norm_o = b_i << shift_o;

endmodule

// File: rtl/riscv_alu_div_ctrl.sv
// Initiator-side controller between the EX-stage request port and the serial divider.
// Optional divider bypass for B==0/B==1 from IDLE: define RISCV_DIV_FASTPATH_EN.
module riscv_alu_div_ctrl
    import riscv_div_pkg::*;
#(
    parameter int unsigned C_WIDTH     = 32,
    parameter int unsigned C_LOG_WIDTH = 6
) (
    input  logic                   Clk_CI,
    input  logic                   Rst_RI,
    input  logic                   Req_SI,
    output logic                   Gnt_SO,
    input  logic [C_WIDTH-1:0]     OpA_DI,
    input  logic [C_WIDTH-1:0]     OpB_DI,
    input  logic [1:0]             OpCode_SI,
    input  logic                   Kill_SI,
    output logic                   Valid_SO,
    input  logic                   Rdy_SI,
    output logic [C_WIDTH-1:0]     Result_DO,
    output logic [C_WIDTH-1:0]     DivOpA_DO,
    output logic [C_WIDTH-1:0]     DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0] DivOpBShift_DO,
    output logic                   DivOpBIsZero_SO,
    output logic                   DivOpBSign_SO,
    output logic [1:0]             DivOpCode_DO,
    output logic                   DivInVld_SO,
    input  logic                   DivOutVld_SI,
    output logic                   DivOutRdy_SO,
    input  logic [C_WIDTH-1:0]     DivRes_DI
);

    div_state_e             state_q;
    logic [C_WIDTH-1:0]     opa_q, opb_q, res_q;
    logic [C_LOG_WIDTH-1:0] shift_q;
    logic                   zero_q, sign_q;
    logic [1:0]             op_q;

    div_op_e                op_in;
    logic                   is_signed, is_rem;
    logic [C_WIDTH-1:0]     b_norm;
    logic [C_LOG_WIDTH-1:0] b_shift;
    logic                   b_zero;
    logic                   gnt;
    logic                   fast;
    logic [C_WIDTH-1:0]     fast_res;

    assign op_in     = div_op_e'(OpCode_SI);
    assign is_signed = (op_in == DIV_DIV) || (op_in == DIV_REM);
    assign is_rem    = (op_in == DIV_UREM) || (op_in == DIV_REM);

    riscv_div_norm #(
        .C_WIDTH    (C_WIDTH),
        .C_LOG_WIDTH(C_LOG_WIDTH)
    ) u_norm (
        .b_i     (OpB_DI),
        .signed_i(is_signed),
        .b_norm_o(b_norm),
        .shift_o (b_shift),
        .zero_o  (b_zero)
    );

`ifdef RISCV_DIV_FASTPATH_EN
    // B==0 or B==1: the answer is known without the divider.
    always_comb begin
        fast     = (state_q == IDLE) && (OpB_DI[C_WIDTH-1:1] == '0);
        fast_res = is_rem ? (b_zero ? OpA_DI : '0) : (b_zero ? '1 : OpA_DI);
    end
`else
    assign fast     = 1'b0;
    assign fast_res = {C_WIDTH{is_rem & 1'b0}};
`endif

    always_comb begin
        gnt = 1'b0;
        case (state_q)
            IDLE:    gnt = Req_SI;
            DONE:    gnt = Req_SI & Rdy_SI & ~Kill_SI;
            default: gnt = 1'b0;
        endcase
        if (Rst_RI) gnt = 1'b0;
    end

    always_ff @(posedge Clk_CI) begin
        if (Rst_RI) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            shift_q <= '0;
            zero_q  <= 1'b0;
            sign_q  <= 1'b0;
            op_q    <= '0;
        end else begin
            if (gnt) begin
                opa_q   <= OpA_DI;
                opb_q   <= b_norm;
                shift_q <= b_shift;
                zero_q  <= b_zero;
                sign_q  <= is_signed & OpB_DI[C_WIDTH-1];
                op_q    <= OpCode_SI;
            end
            case (state_q)
                IDLE: begin
                    if (gnt) begin
                        state_q <= fast ? DONE : ISSUE;
                        if (fast) res_q <= fast_res;
                    end
                end
                ISSUE: begin
                    if (Kill_SI) state_q <= IDLE;
                    else if (DivOutVld_SI) state_q <= WAIT;
                end
                WAIT: begin
                    if (Kill_SI) begin
                        state_q <= DRAIN;
                    end else if (DivOutVld_SI) begin
                        res_q   <= DivRes_DI;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (Kill_SI) state_q <= IDLE;
                    else if (Rdy_SI) state_q <= gnt ? ISSUE : IDLE;
                end
                DRAIN: begin
                    if (DivOutVld_SI) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign Gnt_SO          = gnt;
    assign Valid_SO        = (state_q == DONE);
    assign Result_DO       = res_q;
    assign DivOpA_DO       = opa_q;
    assign DivOpB_DO       = opb_q;
    assign DivOpBShift_DO  = shift_q;
    assign DivOpBIsZero_SO = zero_q;
    assign DivOpBSign_SO   = sign_q;
    assign DivOpCode_DO    = op_q;
    // A kill in ISSUE must suppress the strobe in the same cycle.
    assign DivInVld_SO     = ~Rst_RI & (state_q == ISSUE) & DivOutVld_SI & ~Kill_SI;
    assign DivOutRdy_SO    = ~Rst_RI & ((state_q == WAIT) || (state_q == DRAIN)) & DivOutVld_SI;

endmodule
